// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: constants shared by the scanned seven-segment driver and decoder.
package seg_scan_pkg;
    localparam int DIGITS = 8;
    localparam logic [7:0] BUS_RST = 8'hFF;
    // Active-high abcdefg, bit0 = a; entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] GLYPHS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
endpackage

// File: rtl/seg_glyph_decode.sv
// seg_glyph_decode: maps an active-high abcdefg pattern back to its hex nibble.
module seg_glyph_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic       o_hit,
    output logic [3:0] o_nibble
);
    always_comb begin
        o_hit = 1'b0;
        o_nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (i_seg == GLYPHS[i]) begin
                o_hit = 1'b1;
                o_nibble = 4'(i);
            end
        end
    end
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: reconstructs digits and decimal points from a scanned SEG/AN bus.
// Define SEG_SCAN_DEC_ERR_CNT_EN to add the saturating err_count output.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg_in,
    input  logic [7:0]  an_in,
    output logic [31:0] digits,
    output logic [7:0]  dp,
    output logic [7:0]  valid_mask,
    output logic [7:0]  bad_mask,
    output logic        frame_done,
    output logic        err
`ifdef SEG_SCAN_DEC_ERR_CNT_EN
    ,
    output logic [15:0] err_count
`endif
);
    logic [7:0]  r_seg_m, r_seg_s, r_an_m, r_an_s;
    logic [15:0] r_p;
    logic [7:0]  r_cnt;
    logic [7:0]  r_seen;
    logic [15:0] w_s;
    logic [7:0]  w_an_n;
    logic        w_stable, w_cap, w_one, w_multi, w_hit;
    logic [7:0]  w_sel;
    logic [3:0]  w_nib;

    assign w_s      = {r_an_s, r_seg_s};
    assign w_an_n   = ~w_s[15:8];
    assign w_stable = (w_s == r_p);
    assign w_cap    = w_stable && (r_cnt == 8'(SETTLE_CYCLES - 1));
    assign w_one    = (w_an_n != 8'h0) && ((w_an_n & (w_an_n - 8'd1)) == 8'h0);
    assign w_multi  = (w_an_n != 8'h0) && !w_one;
    // One-hot mask of the digit written by this capture (zero when none).
    assign w_sel    = (w_cap && w_one) ? w_an_n : 8'h0;

    seg_glyph_decode u_dec (
        .i_seg    (~w_s[6:0]),
        .o_hit    (w_hit),
        .o_nibble (w_nib)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_m    <= BUS_RST;
            r_seg_s    <= BUS_RST;
            r_an_m     <= BUS_RST;
            r_an_s     <= BUS_RST;
            r_p        <= {BUS_RST, BUS_RST};
            r_cnt      <= 8'h0;
            r_seen     <= 8'h0;
            digits     <= 32'h0;
            dp         <= 8'h0;
            valid_mask <= 8'h0;
            bad_mask   <= 8'h0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            r_seg_m    <= seg_in;
            r_seg_s    <= r_seg_m;
            r_an_m     <= an_in;
            r_an_s     <= r_an_m;
            r_p        <= w_s;
            r_cnt      <= !w_stable ? 8'h0 : (r_cnt == 8'(SETTLE_CYCLES)) ? r_cnt : r_cnt + 8'd1;
            err        <= w_cap && w_multi;
            frame_done <= &r_seen;
            r_seen     <= ((&r_seen) ? 8'h0 : r_seen) | w_sel;
            valid_mask <= valid_mask | w_sel;
            for (int i = 0; i < DIGITS; i++) begin
                if (w_sel[i]) begin
                    dp[i]       <= ~w_s[7];
                    bad_mask[i] <= !w_hit;
                    if (w_hit) digits[4*i +: 4] <= w_nib;
                end
            end
        end
    end

`ifdef SEG_SCAN_DEC_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_count <= 16'h0;
        else if (err_count != 16'hFFFF && ((w_cap && w_multi) || (|w_sel && !w_hit)))
            err_count <= err_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: random and directed scanning checked against a behavioural model.
module tb_seg_scan_decoder;
    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  seg_in = 8'hFF;
    logic [7:0]  an_in = 8'hFF;
    logic [31:0] digits;
    logic [7:0]  dp, valid_mask, bad_mask;
    logic        frame_done, err;
`ifdef SEG_SCAN_DEC_ERR_CNT_EN
    logic [15:0] err_count;
`endif

    seg_scan_decoder #(.SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .an_in      (an_in),
        .digits     (digits),
        .dp         (dp),
        .valid_mask (valid_mask),
        .bad_mask   (bad_mask),
        .frame_done (frame_done),
        .err        (err)
`ifdef SEG_SCAN_DEC_ERR_CNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input int n);
        case (n)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
            12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; 15: return 7'h71;
            default: return 7'h00;
        endcase
    endfunction

    // Model: an input value sampled on edges E-S-2..E-2 (and not on E-S-3) lands on edge E.
    logic [16:0] h[$];
    logic [31:0] m_dig;
    logic [7:0]  m_dp, m_vm, m_bm, m_seen, an_n;
    logic        m_fd, m_err, cap;
    logic [16:0] v;
    int          m_ec, k, nib;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_dig = 0; m_dp = 0; m_vm = 0; m_bm = 0; m_seen = 0;
                m_fd = 0; m_err = 0; m_ec = 0;
                h.delete();
                for (int i = 0; i < S + 4; i++) h.push_back(17'h10000);
            end else begin
                h.push_back({1'b0, an_in, seg_in});
                void'(h.pop_front());
                v = h[S+1];
                cap = (h[0] != v);
                for (int j = 1; j <= S; j++) if (h[j] != v) cap = 0;
                m_fd = (m_seen == 8'hFF);
                if (m_fd) m_seen = 0;
                m_err = 0;
                if (cap) begin
                    an_n = ~v[15:8];
                    if ($countones(an_n) > 1) begin
                        m_err = 1;
                        if (m_ec < 65535) m_ec++;
                    end else if ($countones(an_n) == 1) begin
                        k = 0;
                        for (int i = 0; i < 8; i++) if (an_n[i]) k = i;
                        nib = -1;
                        for (int i = 0; i < 16; i++) if (glyph(i) == ~v[6:0]) nib = i;
                        m_dp[k] = ~v[7];
                        m_vm[k] = 1;
                        m_seen[k] = 1;
                        if (nib >= 0) begin
                            m_dig[4*k +: 4] = 4'(nib);
                            m_bm[k] = 0;
                        end else begin
                            m_bm[k] = 1;
                            if (m_ec < 65535) m_ec++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("digits", digits, m_dig);
            chk("dp", 32'(dp), 32'(m_dp));
            chk("valid_mask", 32'(valid_mask), 32'(m_vm));
            chk("bad_mask", 32'(bad_mask), 32'(m_bm));
            chk("frame_done", 32'(frame_done), 32'(m_fd));
            chk("err", 32'(err), 32'(m_err));
`ifdef SEG_SCAN_DEC_ERR_CNT_EN
            chk("err_count", 32'(err_count), 32'(m_ec));
`endif
            if (frame_done) fd_cnt++;
            if (err) err_cnt++;
        end
    end

    task automatic hold(input logic [7:0] an, input logic [7:0] seg, input int n);
        an_in = an;
        seg_in = seg;
        repeat (n) @(negedge clk);
    endtask

    int fd0, er0;
    logic [7:0] an_r, b1, b2;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_digits", digits, 32'h0);
        chk("reset_valid", 32'(valid_mask), 32'h0);
        // Latency: first update lands on edge S+3.
        an_in = 8'hFE;
        seg_in = ~8'h06;
        repeat (S + 2) @(negedge clk);
        chk("latency_before", 32'(valid_mask), 32'h0);
        @(negedge clk);
        chk("latency_valid", 32'(valid_mask), 32'h01);
        chk("latency_digit", 32'(digits[3:0]), 32'h1);
        chk("latency_dp", 32'(dp[0]), 32'h0);
        repeat (20 - (S + 3)) @(negedge clk);
        // Full frame 0..7 with DP on digit 5.
        fd0 = fd_cnt;
        for (int d = 0; d < 8; d++) begin
            if (d == 7) chk("frame_early", 32'(fd_cnt - fd0), 32'h0);
            hold(~(8'h01 << d), ~{d == 5, glyph(d)}, 10);
        end
        hold(8'hFF, 8'hFF, 10);
        chk("frame_pulses", 32'(fd_cnt - fd0), 32'h1);
        chk("frame_digits", digits, 32'h76543210);
        chk("frame_dp", 32'(dp), 32'h20);
        // Glitch filter: short runs never land.
        hold(8'hFD, ~8'h7F, 3);
        hold(8'hFD, ~8'h06, 2);
        hold(8'hFD, ~8'h7F, 15);
        chk("glitch_digit", 32'(digits[7:4]), 32'h8);
        // Multiple anodes low.
        er0 = err_cnt;
        hold(8'hFC, ~8'h3F, 10);
        hold(8'hFF, 8'hFF, 4);
        chk("multi_err", 32'(err_cnt - er0), 32'h1);
        chk("multi_digits", digits, 32'h76543280);
        chk("multi_valid", 32'(valid_mask), 32'hFF);
        // Unrecognised glyph.
        hold(8'hFB, ~8'h55, 10);
        hold(8'hFF, 8'hFF, 4);
        chk("miss_bad", 32'(bad_mask), 32'h04);
        chk("miss_digits", digits, 32'h76543280);
`ifdef SEG_SCAN_DEC_ERR_CNT_EN
        chk("miss_errcount", 32'(err_count), 32'h2);
`endif
        // Reset mid-frame, then a full post-reset frame.
        for (int d = 0; d < 4; d++) hold(~(8'h01 << d), ~{1'b0, glyph(d + 9)}, 8);
        #1 rst = 1'b1;
        an_in = 8'hFF;
        seg_in = 8'hFF;
        @(negedge clk);
        chk("rst_valid", 32'(valid_mask), 32'h0);
        chk("rst_digits", digits, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fd0 = fd_cnt;
        for (int d = 0; d < 8; d++) begin
            if (d == 7) chk("rst_frame_early", 32'(fd_cnt - fd0), 32'h0);
            hold(~(8'h01 << d), ~{1'b0, glyph(d + 8)}, 8);
        end
        hold(8'hFF, 8'hFF, 10);
        chk("rst_frame_pulses", 32'(fd_cnt - fd0), 32'h1);
        chk("rst_frame_digits", digits, 32'hFEDCBA98);
        // Random scanning.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0: an_r = 8'hFF;
                1: begin
                    b1 = 8'h01 << $urandom_range(0, 7);
                    b2 = 8'h01 << $urandom_range(0, 7);
                    if (b1 == b2) b2 = {b1[6:0], b1[7]};
                    an_r = ~(b1 | b2);
                end
                default: an_r = ~(8'h01 << $urandom_range(0, 7));
            endcase
            if ($urandom_range(0, 3) == 0) hold(an_r, 8'($urandom), $urandom_range(1, 12));
            else hold(an_r, ~{1'($urandom), glyph($urandom_range(0, 15))}, $urandom_range(1, 12));
        end
        hold(8'hFF, 8'hFF, 10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
